// File: rtl/lc3_datapath_mc.sv
// LC-3 style multi-cycle datapath: single shared bus, register file, ALU, address adder,
// architectural registers and a handshaked memory sequencer with an ack timeout.
module lc3_datapath_mc #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int LED_W   = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        LD,
  input  logic [3:0]        GATE,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic              MEM_START,
  input  logic              MEM_WE,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              MEM_BUSY,
  output logic              MEM_DONE,
  output logic              MEM_ERR,
  output logic              BUS_ERR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [2:0]        CC,
  output logic              BEN,
  output logic [LED_W-1:0]  LED,
  output logic [1:0]        mem_state_o
);
  localparam int RW = $clog2(NREG);
  localparam int CW = 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} mem_state_e;

  mem_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic              we_q, we_d, err_q, err_d;

  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [2:0]        cc_q, cc_d;
  logic              ben_q, ben_d, bus_err_q, bus_err_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic [RW-1:0]     dr_idx, sr1_idx, sr2_idx;
  logic [DATA_W-1:0] imm5, imm6, imm9, imm11;
  logic [DATA_W-1:0] sr1_val, sr2_val, alu_out, addr1, addr2, addr_sum, bus;
  logic              gate_multi, rd_done, bus_n, bus_z;

  assign imm5  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign imm6  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign imm9  = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
  assign imm11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

  assign dr_idx  = DRMUX  ? RW'(ir_q[11:9]) : RW'(NREG - 1);
  assign sr1_idx = SR1MUX ? RW'(ir_q[8:6])  : RW'(ir_q[11:9]);
  assign sr2_idx = RW'(ir_q[2:0]);
  assign sr1_val = rf_q[sr1_idx];
  assign sr2_val = SR2MUX ? imm5 : rf_q[sr2_idx];
  assign addr1   = ADDR1MUX ? sr1_val : pc_q;
  assign addr_sum = addr1 + addr2;

  always_comb begin
    alu_out = sr1_val;
    case (ALUK)
      2'd0:    alu_out = sr1_val + sr2_val;
      2'd1:    alu_out = sr1_val & sr2_val;
      2'd2:    alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'd1:    addr2 = imm6;
      2'd2:    addr2 = imm9;
      2'd3:    addr2 = imm11;
      default: addr2 = '0;
    endcase
  end

  // Any pattern other than a single gate bit leaves the bus at zero.
  assign gate_multi = (GATE & (GATE - 4'd1)) != 4'd0;
  always_comb begin
    bus = '0;
    case (GATE)
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = alu_out;
      4'b0001: bus = addr_sum;
      default: bus = '0;
    endcase
  end

  assign bus_n   = bus[DATA_W-1];
  assign bus_z   = (bus == '0);
  assign rd_done = (state_q == S_REQ) && mem_ack && !we_q;

  always_comb begin
    pc_d = pc_q;
    if (LD[1]) begin
      case (PCMUX)
        2'd0:    pc_d = pc_q + DATA_W'(1);
        2'd1:    pc_d = bus;
        2'd2:    pc_d = addr_sum;
        default: pc_d = pc_q;
      endcase
    end
    mar_d     = LD[7] ? bus : mar_q;
    ir_d      = LD[5] ? bus : ir_q;
    // A completing read takes priority over a bus load in the same cycle.
    mdr_d     = rd_done ? mem_rdata : (LD[6] ? bus : mdr_q);
    ben_d     = LD[4] ? |(ir_q[11:9] & cc_q) : ben_q;
    cc_d      = LD[3] ? {bus_n, bus_z, !bus_n && !bus_z} : cc_q;
    led_d     = LD[0] ? ir_q[LED_W-1:0] : led_q;
    bus_err_d = bus_err_q | gate_multi;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      cc_q      <= 3'b010;
      ben_q     <= 1'b0;
      led_q     <= '0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      cc_q      <= cc_d;
      ben_q     <= ben_d;
      led_q     <= led_d;
      bus_err_q <= bus_err_d;
      if (LD[2]) rf_q[dr_idx] <= bus;
    end
  end

  // Memory sequencer: request fields are captured on acceptance and held through REQ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (MEM_START) begin
          addr_d  = mar_q;
          wdata_d = mdr_q;
          we_d    = MEM_WE;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign mem_req     = (state_q == S_REQ);
  assign MEM_BUSY    = (state_q == S_REQ);
  assign MEM_DONE    = (state_q == S_DONE);
  assign MEM_ERR     = err_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_state_o = state_q;
  assign BUS_ERR     = bus_err_q;
  assign PC          = pc_q;
  assign IR          = ir_q;
  assign MAR         = mar_q;
  assign MDR         = mdr_q;
  assign CC          = cc_q;
  assign BEN         = ben_q;
  assign LED         = led_q;
endmodule

// File: tb/tb_lc3_datapath_mc.sv
// Bench for lc3_datapath_mc: a 16-bit and a 32-bit instance share all controls; directed
// vectors push expectations into queues that negedge monitors pop and compare.
module tb_lc3_datapath_mc;
  localparam int TO = 4;
  localparam logic [7:0] L_MAR = 8'h80, L_MDR = 8'h40, L_IR = 8'h20, L_BEN = 8'h10;
  localparam logic [7:0] L_CC = 8'h08, L_REG = 8'h04, L_PC = 8'h02, L_LED = 8'h01;
  localparam logic [3:0] G_PC = 4'b1000, G_MDR = 4'b0100, G_ALU = 4'b0010, G_ADR = 4'b0001;
  localparam int F_PC = 0, F_IR = 1, F_MAR = 2, F_MDR = 3, F_CC = 4, F_BEN = 5, F_LED = 6;
  localparam int F_BUSERR = 7, F_MEMREQ = 8, F_MEMERR = 9, F_STATE = 10, F_MEMADDR = 11;
  localparam int F_WDATA = 12, F_MEMWE = 13, F_PC32 = 14, F_MAR32 = 15, F_CC32 = 16, F_BUSY = 17;

  typedef struct { int unsigned cyc; int fld; logic [31:0] val; } exp_t;
  typedef struct { logic [15:0] mdr16; logic [31:0] mdr32; logic err; int reqs; } done_t;

  logic        Clk = 1'b0, Reset;
  logic [7:0]  LD;
  logic [3:0]  GATE;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MEM_START, MEM_WE, mem_ack;
  logic [15:0] rdata16;
  logic [31:0] rdata32;

  logic        mem_req_a, mem_we_a, busy_a, done_a, err_a, buserr_a, ben_a;
  logic [15:0] mem_addr_a, mem_wdata_a, pc_a, ir_a, mar_a, mdr_a;
  logic [2:0]  cc_a;
  logic [11:0] led_a;
  logic [1:0]  state_a;
  logic        mem_req_b, mem_we_b, busy_b, done_b, err_b, buserr_b, ben_b;
  logic [31:0] mem_addr_b, mem_wdata_b, pc_b, ir_b, mar_b, mdr_b;
  logic [2:0]  cc_b;
  logic [11:0] led_b;
  logic [1:0]  state_b;

  exp_t        exp_q[$];
  done_t       done_q[$];
  int unsigned cyc = 0;
  int          checks = 0, errors = 0, req_cnt = 0;
  logic [15:0] mar_m = '0, mdr_m = '0;

  lc3_datapath_mc #(.DATA_W(16), .NREG(8), .LED_W(12), .TIMEOUT(TO)) u16 (
    .Clk(Clk), .Reset(Reset), .LD(LD), .GATE(GATE), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MEM_START(MEM_START), .MEM_WE(MEM_WE), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(rdata16), .mem_ack(mem_ack),
    .MEM_BUSY(busy_a), .MEM_DONE(done_a), .MEM_ERR(err_a), .BUS_ERR(buserr_a),
    .PC(pc_a), .IR(ir_a), .MAR(mar_a), .MDR(mdr_a), .CC(cc_a), .BEN(ben_a), .LED(led_a),
    .mem_state_o(state_a));

  lc3_datapath_mc #(.DATA_W(32), .NREG(8), .LED_W(12), .TIMEOUT(TO)) u32 (
    .Clk(Clk), .Reset(Reset), .LD(LD), .GATE(GATE), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MEM_START(MEM_START), .MEM_WE(MEM_WE), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(rdata32), .mem_ack(mem_ack),
    .MEM_BUSY(busy_b), .MEM_DONE(done_b), .MEM_ERR(err_b), .BUS_ERR(buserr_b),
    .PC(pc_b), .IR(ir_b), .MAR(mar_b), .MDR(mdr_b), .CC(cc_b), .BEN(ben_b), .LED(led_b),
    .mem_state_o(state_b));

  // Clock and cycle counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic string fname(int f);
    case (f)
      F_PC: return "pc";          F_IR: return "ir";          F_MAR: return "mar";
      F_MDR: return "mdr";        F_CC: return "cc";          F_BEN: return "ben";
      F_LED: return "led";        F_BUSERR: return "bus_err"; F_MEMREQ: return "mem_req";
      F_MEMERR: return "mem_err"; F_STATE: return "state";    F_MEMADDR: return "mem_addr";
      F_WDATA: return "mem_wdata"; F_MEMWE: return "mem_we";  F_PC32: return "pc32";
      F_MAR32: return "mar32";    F_CC32: return "cc32";      F_BUSY: return "mem_busy";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(int f);
    case (f)
      F_PC: return 32'(pc_a);         F_IR: return 32'(ir_a);       F_MAR: return 32'(mar_a);
      F_MDR: return 32'(mdr_a);       F_CC: return 32'(cc_a);       F_BEN: return 32'(ben_a);
      F_LED: return 32'(led_a);       F_BUSERR: return 32'(buserr_a);
      F_MEMREQ: return 32'(mem_req_a); F_MEMERR: return 32'(err_a); F_STATE: return 32'(state_a);
      F_MEMADDR: return 32'(mem_addr_a); F_WDATA: return 32'(mem_wdata_a);
      F_MEMWE: return 32'(mem_we_a);  F_PC32: return pc_b;          F_MAR32: return mar_b;
      F_CC32: return 32'(cc_b);       F_BUSY: return 32'(busy_a);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_ctl();
    LD = '0; GATE = '0; PCMUX = '0; ADDR2MUX = '0; ALUK = '0;
    DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0;
  endtask

  task automatic exp(int f, logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.fld = f; e.val = v;
    exp_q.push_back(e);
    if (f == F_MAR) mar_m = v[15:0];
    if (f == F_MDR) mdr_m = v[15:0];
  endtask

  task automatic op(logic [7:0] ld, logic [3:0] gate, logic [1:0] pcm, logic a1,
                    logic [1:0] a2, logic [1:0] aluk, logic s1, logic s2, logic drm);
    LD = ld; GATE = gate; PCMUX = pcm; ADDR1MUX = a1; ADDR2MUX = a2;
    ALUK = aluk; SR1MUX = s1; SR2MUX = s2; DRMUX = drm;
    tick();
    idle_ctl();
  endtask

  // ack_at = 0 means no ack, so the transaction runs into the timeout.
  task automatic mem_txn(logic we, logic [15:0] d16, logic [31:0] d32, int ack_at,
                         logic [15:0] m16, logic [31:0] m32, logic err, logic poke, logic ld_on_ack);
    done_t d;
    d.mdr16 = m16; d.mdr32 = m32; d.err = err; d.reqs = (ack_at > 0) ? ack_at : TO;
    done_q.push_back(d);
    MEM_START = 1; MEM_WE = we;
    tick();
    MEM_START = 0;
    exp(F_MEMREQ, 1); exp(F_BUSY, 1); exp(F_MEMADDR, 32'(mar_m));
    exp(F_WDATA, 32'(mdr_m)); exp(F_MEMWE, 32'(we));
    for (int i = 1; i <= d.reqs; i++) begin
      if (poke && i == 2) MEM_START = 1;
      if (i == ack_at) begin
        mem_ack = 1; rdata16 = d16; rdata32 = d32;
        if (ld_on_ack) begin LD = L_MDR; GATE = G_PC; end
      end
      tick();
      MEM_START = 0; mem_ack = 0;
      idle_ctl();
      if (poke && i == 2) exp(F_MEMADDR, 32'(mar_m));
    end
    tick();
    mdr_m = m16;
  endtask

  task automatic load_mdr(logic [15:0] d16, logic [31:0] d32);
    mem_txn(1'b0, d16, d32, 1, d16, d32, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitors
  always @(negedge Clk) begin : exp_monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      cmp(fname(e.fld), observe(e.fld), e.val);
    end
  end

  always @(negedge Clk) begin : done_monitor
    done_t d;
    if (!Reset) begin
      req_cnt = 0;
    end else begin
      if (mem_req_a) req_cnt++;
      if (done_a) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got MEM_DONE=1, expected no completion");
        end else begin
          d = done_q.pop_front();
          cmp("done_mdr", 32'(mdr_a), 32'(d.mdr16));
          cmp("done_mdr32", mdr_b, d.mdr32);
          cmp("done_err", 32'(err_a), 32'(d.err));
          cmp("done_req_cycles", 32'(req_cnt), 32'(d.reqs));
          cmp("done32_aligned", 32'(done_b), 32'd1);
        end
        req_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 0; idle_ctl(); MEM_START = 0; MEM_WE = 0; mem_ack = 0; rdata16 = '0; rdata32 = '0;
    tick(); tick();
    exp(F_PC, 0); exp(F_IR, 0); exp(F_MAR, 0); exp(F_MDR, 0); exp(F_CC, 3'b010);
    exp(F_BEN, 0); exp(F_LED, 0); exp(F_BUSERR, 0); exp(F_MEMERR, 0); exp(F_MEMREQ, 0);
    exp(F_STATE, 0); exp(F_PC32, 0); exp(F_CC32, 3'b010);
    tick(); Reset = 1; tick();

    // Condition codes and branch enable
    load_mdr(16'h8000, 32'h8000_0000);
    op(L_CC, G_MDR, 0, 0, 0, 0, 0, 0, 0);   exp(F_CC, 3'b100); exp(F_CC32, 3'b100);
    load_mdr(16'h0E00, 32'h0E00);
    op(L_IR, G_MDR, 0, 0, 0, 0, 0, 0, 0);   exp(F_IR, 16'h0E00);
    op(L_BEN, 4'b0, 0, 0, 0, 0, 0, 0, 0);   exp(F_BEN, 1);
    load_mdr(16'h0200, 32'h0200);
    op(L_IR, G_MDR, 0, 0, 0, 0, 0, 0, 0);
    op(L_BEN, 4'b0, 0, 0, 0, 0, 0, 0, 0);   exp(F_BEN, 0);
    op(L_CC, 4'b0, 0, 0, 0, 0, 0, 0, 0);    exp(F_CC, 3'b010); exp(F_CC32, 3'b010);

    // PC wrap and PC-relative load
    load_mdr(16'hFFFF, 32'hFFFF_FFFF);
    op(L_PC, G_MDR, 1, 0, 0, 0, 0, 0, 0);   exp(F_PC, 16'hFFFF); exp(F_PC32, 32'hFFFF_FFFF);
    op(L_PC, 4'b0, 0, 0, 0, 0, 0, 0, 0);    exp(F_PC, 0); exp(F_PC32, 0);
    load_mdr(16'h3000, 32'h3000);
    op(L_PC, G_MDR, 1, 0, 0, 0, 0, 0, 0);   exp(F_PC, 16'h3000); exp(F_PC32, 32'h3000);
    load_mdr(16'h01FF, 32'h01FF);
    op(L_IR, G_MDR, 0, 0, 0, 0, 0, 0, 0);   exp(F_IR, 16'h01FF);
    op(L_PC, 4'b0, 2, 0, 2, 0, 0, 0, 0);    exp(F_PC, 16'h2FFF); exp(F_PC32, 32'h2FFF);
    op(L_PC, 4'b0, 3, 0, 0, 0, 0, 0, 0);    exp(F_PC, 16'h2FFF);
    op(L_PC, 4'b0, 0, 0, 0, 0, 0, 0, 0);    exp(F_PC, 16'h3000); exp(F_PC32, 32'h3000);
    op(L_MAR, G_PC, 0, 0, 0, 0, 0, 0, 0);   exp(F_MAR, 16'h3000);

    // Register file, ALU and address adder
    load_mdr(16'h1234, 32'h1234);
    op(L_REG, G_MDR, 0, 0, 0, 0, 0, 0, 0);
    load_mdr(16'h05C7, 32'h05C7);
    op(L_IR, G_MDR, 0, 0, 0, 0, 0, 0, 0);   exp(F_IR, 16'h05C7);
    op(L_MAR, G_ALU, 0, 0, 0, 0, 1, 0, 0);  exp(F_MAR, 16'h2468); exp(F_MAR32, 32'h2468);
    op(L_MAR, G_ALU, 0, 0, 0, 0, 1, 1, 0);  exp(F_MAR, 16'h123B); exp(F_MAR32, 32'h123B);
    op(L_MAR, G_ALU, 0, 0, 0, 1, 1, 1, 0);  exp(F_MAR, 16'h0004);
    op(L_MAR | L_REG, G_ALU, 0, 0, 0, 2, 1, 0, 1);
    exp(F_MAR, 16'hEDCB); exp(F_MAR32, 32'hFFFF_EDCB);
    op(L_MAR, G_ALU, 0, 0, 0, 3, 0, 0, 0);  exp(F_MAR, 16'hEDCB); exp(F_MAR32, 32'hFFFF_EDCB);
    op(L_MAR | L_CC, G_ALU, 0, 0, 0, 0, 0, 0, 0);
    exp(F_MAR, 16'hFFFF); exp(F_MAR32, 32'hFFFF_FFFF); exp(F_CC, 3'b100); exp(F_CC32, 3'b100);
    load_mdr(16'h0FDF, 32'h0FDF);
    op(L_IR, G_MDR, 0, 0, 0, 0, 0, 0, 0);   exp(F_IR, 16'h0FDF);
    op(L_MAR, G_ALU, 0, 0, 0, 0, 1, 1, 0);  exp(F_MAR, 16'h1233); exp(F_MAR32, 32'h1233);
    op(L_MAR, G_ADR, 0, 1, 1, 0, 1, 0, 0);  exp(F_MAR, 16'h1253);
    op(L_MAR, G_ADR, 0, 1, 3, 0, 1, 0, 0);  exp(F_MAR, 16'h1213); exp(F_MAR32, 32'h1213);
    op(L_MAR | L_LED, G_ADR, 0, 1, 0, 0, 1, 0, 0);  exp(F_MAR, 16'h1234); exp(F_LED, 12'hFDF);

    // Memory sequencer: acked read, timeout with ignored restart, write, MDR priority
    load_mdr(16'h0040, 32'h0040);
    op(L_MAR, G_MDR, 0, 0, 0, 0, 0, 0, 0);  exp(F_MAR, 16'h0040);
    mem_txn(1'b0, 16'hBEEF, 32'hBEEF, 3, 16'hBEEF, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    exp(F_MEMERR, 0);
    mem_txn(1'b0, 16'h0000, 32'h0, 0, 16'hBEEF, 32'hBEEF, 1'b1, 1'b1, 1'b0);
    exp(F_MEMERR, 1); exp(F_STATE, 0); exp(F_MDR, 16'hBEEF);
    mem_txn(1'b1, 16'h0000, 32'h0, 2, 16'hBEEF, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    op(L_MDR, G_PC, 0, 0, 0, 0, 0, 0, 0);   exp(F_MDR, 16'h3000);
    mem_txn(1'b0, 16'h5A5A, 32'h5A5A, 1, 16'h5A5A, 32'h5A5A, 1'b0, 1'b0, 1'b1);

    // Illegal gate pattern
    op(L_MAR, 4'b1010, 0, 0, 0, 0, 0, 0, 0); exp(F_MAR, 0); exp(F_BUSERR, 1);
    op(L_MAR, G_MDR, 0, 0, 0, 0, 0, 0, 0);  exp(F_MAR, 16'h5A5A); exp(F_BUSERR, 1);

    // Asynchronous reset in the middle of a request
    MEM_START = 1; tick(); MEM_START = 0; tick();
    exp(F_MEMREQ, 1);
    #5 Reset = 0;
    #1;
    cmp("async_reset_mem_req", 32'(mem_req_a), 32'd0);
    cmp("async_reset_mem_req32", 32'(mem_req_b), 32'd0);
    mem_ack = 1; rdata16 = 16'hFACE; rdata32 = 32'hFACE;
    tick();
    exp(F_MDR, 0); exp(F_PC, 0); exp(F_IR, 0); exp(F_MAR, 0); exp(F_CC, 3'b010);
    exp(F_LED, 0); exp(F_BUSERR, 0); exp(F_MEMERR, 0); exp(F_STATE, 0); exp(F_MEMREQ, 0);
    exp(F_PC32, 0); exp(F_CC32, 3'b010);
    mem_ack = 0; Reset = 1;
    tick(); tick();
    exp(F_STATE, 0); exp(F_MDR, 0); exp(F_BUSERR, 0);
    tick(); tick();

    if (exp_q.size() != 0 || done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations: got %0d/%0d pending, expected 0/0",
               exp_q.size(), done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
